// File: rtl/branch_predictor_unit.sv
// ---------------------------------------------------------------------------
// branch_predictor_unit
//
// Branch prediction unit for the RISC16 pipeline. It holds a direct-mapped,
// tagged branch target buffer (BTB), a table of saturating direction
// counters (bimodal or gshare indexed), a global history register and
// saturating statistics counters.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   lk_pc_i            PC being fetched (IF stage lookup, combinational)
//   lk_valid_i         lookup is real and is counted in statistics
//   lk_hit_o           BTB entry valid and tag matches
//   lk_taken_o         predicted taken
//   lk_next_pc_o       predicted next PC
//   lk_ghist_o         current global history, carried down the pipeline
//   up_valid_i         resolved control-transfer update (EX/WB stage)
//   up_pc_i            PC of the resolved instruction
//   up_taken_i         actual outcome
//   up_target_i        actual target
//   up_is_jump_i       unconditional jump
//   up_ghist_i         history captured at this instruction's lookup
//   up_pred_taken_i    direction predicted for this instruction
//   up_pred_pc_i       next PC predicted for this instruction
//   up_mispred_o       combinational mispredict flag for the current update
//   stat_lookups_o     saturating count of counted lookups
//   stat_updates_o     saturating count of updates
//   stat_mispred_o     saturating count of mispredicts
// ---------------------------------------------------------------------------
module branch_predictor_unit #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 8,
  parameter int GSHARE = 0,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc_i,
  input  logic              lk_valid_i,
  output logic              lk_hit_o,
  output logic              lk_taken_o,
  output logic [ADDR_W-1:0] lk_next_pc_o,
  output logic [HIST_W-1:0] lk_ghist_o,
  input  logic              up_valid_i,
  input  logic [ADDR_W-1:0] up_pc_i,
  input  logic              up_taken_i,
  input  logic [ADDR_W-1:0] up_target_i,
  input  logic              up_is_jump_i,
  input  logic [HIST_W-1:0] up_ghist_i,
  input  logic              up_pred_taken_i,
  input  logic [ADDR_W-1:0] up_pred_pc_i,
  output logic              up_mispred_o,
  output logic [STAT_W-1:0] stat_lookups_o,
  output logic [STAT_W-1:0] stat_updates_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 1;
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [HIST_W-1:0] ghist_q, ghist_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [STAT_W-1:0] stat_lookups_q, stat_updates_q, stat_mispred_q;

  logic [IDX_W-1:0]  lk_idx, lk_cidx, up_idx, up_cidx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_actual_taken, up_entry_hit;
  logic [CNT_W-1:0]  up_cnt_cur;
  logic              unused_bits;

  // PC bit 0 is always zero for 2-byte aligned code, so it never takes part
  // in indexing; in bimodal mode the update history is also unused.
  assign unused_bits = ^{up_pc_i[0], up_ghist_i};

  assign lk_idx = lk_pc_i[IDX_W:1];
  assign lk_tag = lk_pc_i[ADDR_W-1:IDX_W+1];
  assign up_idx = up_pc_i[IDX_W:1];
  assign up_tag = up_pc_i[ADDR_W-1:IDX_W+1];

  // Counter index: gshare folds the (zero-extended) history into the low
  // index bits; lookups use the live history, updates use the history that
  // was captured when the resolved instruction was looked up.
  generate
    if (GSHARE != 0) begin : g_gshare
      assign lk_cidx = lk_idx ^ IDX_W'(ghist_q);
      assign up_cidx = up_idx ^ IDX_W'(up_ghist_i);
    end else begin : g_bimodal
      assign lk_cidx = lk_idx;
      assign up_cidx = up_idx;
    end
  endgenerate

  // Lookup outputs are forced to the "no prediction" values while reset is
  // held, because the tables only clear at the reset edge.
  assign lk_hit_o     = !rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken_o   = lk_hit_o && cnt_q[lk_cidx][CNT_W-1];
  assign lk_next_pc_o = lk_taken_o ? target_q[lk_idx] : lk_pc_i + ADDR_W'(2);
  assign lk_ghist_o   = rst ? '0 : ghist_q;

  assign up_actual_taken = up_taken_i || up_is_jump_i;
  assign up_entry_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_mispred_o    = up_valid_i &&
                           ((up_pred_taken_i != up_actual_taken) ||
                            (up_actual_taken && (up_pred_pc_i != up_target_i)));

  assign ghist_d = HIST_W'({ghist_q, up_taken_i});

  // Next direction-counter value for the updated slot. Jumps force strongly
  // taken; a taken branch that misses in the BTB gets a fresh entry and its
  // counter restarts at weakly taken rather than inheriting the old count.
  always_comb begin
    up_cnt_cur = cnt_q[up_cidx];
    cnt_d      = up_cnt_cur;
    if (up_is_jump_i) begin
      cnt_d = '1;
    end else if (up_taken_i && !up_entry_hit) begin
      cnt_d = CNT_WEAK_T;
    end else if (up_taken_i) begin
      if (up_cnt_cur != '1) cnt_d = up_cnt_cur + 1'b1;
    end else begin
      if (up_cnt_cur != '0) cnt_d = up_cnt_cur - 1'b1;
    end
  end

  // Valid bits, counters, history and statistics. Reset wins over any
  // update presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '{default: 1'b0};
      cnt_q          <= '{default: CNT_WEAK_NT};
      ghist_q        <= '0;
      stat_lookups_q <= '0;
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (up_valid_i) begin
        if (up_actual_taken) valid_q[up_idx] <= 1'b1;
        cnt_q[up_cidx] <= cnt_d;
        if (!up_is_jump_i) ghist_q <= ghist_d;
      end
      if (lk_valid_i && (stat_lookups_q != '1)) stat_lookups_q <= stat_lookups_q + 1'b1;
      if (up_valid_i && (stat_updates_q != '1)) stat_updates_q <= stat_updates_q + 1'b1;
      if (up_mispred_o && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + 1'b1;
    end
  end

  // BTB payload needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && up_valid_i && up_actual_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= up_target_i;
    end
  end

  assign stat_lookups_o = stat_lookups_q;
  assign stat_updates_o = stat_updates_q;
  assign stat_mispred_o = stat_mispred_q;

endmodule
